// File: rtl/knn_front_ctrl_if.sv
// Engine-side bus of the k-NN front-end controller.
// Carries the latched query, the K-mode select and the start/done handshake.
//   master (front-end): drives eng_start, query_x, query_y, k_sel, k_value;
//                       receives eng_done, eng_class
//   slave  (engine)   : the mirror image
interface knn_front_ctrl_if;
    logic       eng_start;
    logic       eng_done;
    logic       eng_class;
    logic [7:0] query_x;
    logic [7:0] query_y;
    logic       k_sel;
    logic [2:0] k_value;

    modport master (
        output eng_start,
        output query_x,
        output query_y,
        output k_sel,
        output k_value,
        input  eng_done,
        input  eng_class
    );

    modport slave (
        input  eng_start,
        input  query_x,
        input  query_y,
        input  k_sel,
        input  k_value,
        output eng_done,
        output eng_class
    );
endinterface

// File: rtl/knn_front_ctrl.sv
// Operator front-end for the k-NN classification engine.
// Synchronises and debounces four push-buttons, latches the query coordinates
// from the switches, owns the K-mode select, launches the engine with a
// one-cycle start, times the run and shows class/K-mode/latency on the LEDs.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i_switches        query coordinate (signed Q4.4)
//   i_btn_*           raw push-buttons: load_x, load_y, start, toggle_k
//   o_busy            high while a run is being started or awaited
//   o_leds            [0]=class, [1]=k_sel, [7:2]=latency in engine cycles
//   eng               engine-side bus (master modport)
module knn_front_ctrl #(
    parameter int unsigned DB_CYCLES = 2,
    parameter int unsigned LAT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       i_switches,
    input  logic             i_btn_load_x,
    input  logic             i_btn_load_y,
    input  logic             i_btn_start,
    input  logic             i_btn_toggle_k,
    output logic             o_busy,
    output logic [7:0]       o_leds,
    knn_front_ctrl_if.master eng
);

    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned CNT_W   = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam int unsigned BTN_LX  = 0;
    localparam int unsigned BTN_LY  = 1;
    localparam int unsigned BTN_ST  = 2;
    localparam int unsigned BTN_TG  = 3;
    // Counter value at which the next differing sample completes the debounce.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_RESULT
    } state_t;

    logic [NUM_BTN-1:0] w_btn_raw;
    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_stable;
    logic [NUM_BTN-1:0] r_stable_d;
    logic [NUM_BTN-1:0] r_press;
    logic [CNT_W-1:0]   r_db_cnt [NUM_BTN];

    state_t             r_state;
    logic [7:0]         r_query_x;
    logic [7:0]         r_query_y;
    logic               r_k_sel;
    logic               r_eng_start;
    logic               r_busy;
    logic               r_armed;
    logic [LAT_W-1:0]   r_lat;
    logic [LAT_W-1:0]   w_lat_inc;
    logic               r_led_cls;
    logic [LAT_W-1:0]   r_led_lat;

    assign w_btn_raw = {i_btn_toggle_k, i_btn_start, i_btn_load_y, i_btn_load_x};

    // Two-flop synchroniser, debounce counter and rising-edge press pulse per button.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_press    <= '0;
            for (int b = 0; b < NUM_BTN; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            r_sync1    <= w_btn_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            for (int b = 0; b < NUM_BTN; b++) begin
                if (r_sync2[b] == r_stable[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_LAST) begin
                    r_stable[b] <= r_sync2[b];
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // Saturating latency increment.
    assign w_lat_inc = (&r_lat) ? r_lat : r_lat + LAT_W'(1);

    // Control FSM: button actions in IDLE/RESULT, start pulse, run timing, result latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_query_x   <= '0;
            r_query_y   <= '0;
            r_k_sel     <= 1'b0;
            r_eng_start <= 1'b0;
            r_busy      <= 1'b0;
            r_armed     <= 1'b0;
            r_lat       <= '0;
            r_led_cls   <= 1'b0;
            r_led_lat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESULT: begin
                    if (r_press[BTN_LX]) r_query_x <= i_switches;
                    if (r_press[BTN_LY]) r_query_y <= i_switches;
                    if (r_press[BTN_TG]) r_k_sel   <= ~r_k_sel;
                    if (r_press[BTN_ST]) begin
                        r_state     <= ST_START;
                        r_eng_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    r_eng_start <= 1'b0;
                    r_lat       <= '0;
                    r_armed     <= 1'b0;
                    r_state     <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    r_lat <= w_lat_inc;
                    // A done level left over from the previous run only counts
                    // once the engine has been seen low after this start.
                    if (r_armed && eng.eng_done) begin
                        r_led_cls <= eng.eng_class;
                        r_led_lat <= w_lat_inc;
                        r_busy    <= 1'b0;
                        r_state   <= ST_RESULT;
                    end else if (!eng.eng_done) begin
                        r_armed <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng.eng_start = r_eng_start;
    assign eng.query_x   = r_query_x;
    assign eng.query_y   = r_query_y;
    assign eng.k_sel     = r_k_sel;
    assign eng.k_value   = r_k_sel ? 3'd5 : 3'd3;

    assign o_busy = r_busy;
    assign o_leds = {6'(r_led_lat), r_k_sel, r_led_cls};

endmodule

// File: tb/tb_knn_front_ctrl.sv
// Bench for knn_front_ctrl: button presses, query/K latching, engine runs
// with stale done levels, latency saturation and mid-run reset.
module tb_knn_front_ctrl;

    localparam int LAT_MAX = 63;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] switches = 8'h00;
    logic       b_lx = 1'b0;
    logic       b_ly = 1'b0;
    logic       b_st = 1'b0;
    logic       b_tg = 1'b0;
    logic       busy;
    logic [7:0] leds;

    knn_front_ctrl_if u_if ();

    knn_front_ctrl #(
        .DB_CYCLES (2),
        .LAT_W     (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_switches     (switches),
        .i_btn_load_x   (b_lx),
        .i_btn_load_y   (b_ly),
        .i_btn_start    (b_st),
        .i_btn_toggle_k (b_tg),
        .o_busy         (busy),
        .o_leds         (leds),
        .eng            (u_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected operator-visible state
    logic [7:0] exp_qx = 8'h00;
    logic [7:0] exp_qy = 8'h00;
    logic       exp_k  = 1'b0;

    // Engine model: done high for offsets 1..stale after start, low until
    // done_at, then high (level) until the next start.
    int   eng_stale   = 0;
    int   eng_done_at = 10;
    logic eng_cls_v   = 1'b0;
    int   eng_off     = 0;
    bit   eng_run     = 1'b0;
    int   start_cnt   = 0;
    logic tb_done     = 1'b0;
    logic tb_cls      = 1'b0;
    logic [7:0] seen_qx = 8'h00;
    logic [7:0] seen_qy = 8'h00;
    logic       seen_k  = 1'b0;

    assign u_if.eng_done  = tb_done;
    assign u_if.eng_class = tb_cls;

    function automatic bit sched(int k, int stale, int done_at);
        return (k <= stale) || (k >= done_at);
    endfunction

    // Latency the operator should see: first offset with done high after a low.
    function automatic int ref_latency(int stale, int done_at);
        bit seen_low;
        bit d;
        seen_low = 1'b0;
        for (int k = 1; k < 100000; k++) begin
            d = sched(k, stale, done_at);
            if (d && seen_low) return (k > LAT_MAX) ? LAT_MAX : k;
            if (!d) seen_low = 1'b1;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (u_if.eng_start) begin
            start_cnt = start_cnt + 1;
            eng_off   = 0;
            eng_run   = 1'b1;
            seen_qx   = u_if.query_x;
            seen_qy   = u_if.query_y;
            seen_k    = u_if.k_sel;
        end else if (eng_run) begin
            eng_off = eng_off + 1;
            tb_done = sched(eng_off, eng_stale, eng_done_at);
            tb_cls  = eng_cls_v;
            if (eng_off >= eng_done_at) eng_run = 1'b0;
        end
    end

    // Raise the masked buttons now (at a falling edge) for 'hold' cycles.
    // mask bits: 0 load_x, 1 load_y, 2 start, 3 toggle
    task automatic press(input int mask, input int hold);
        b_lx = mask[0];
        b_ly = mask[1];
        b_st = mask[2];
        b_tg = mask[3];
        repeat (hold) @(negedge clk);
        b_lx = 1'b0;
        b_ly = 1'b0;
        b_st = 1'b0;
        b_tg = 1'b0;
    endtask

    task automatic wait_start(input int c0);
        for (int i = 0; i < 20 && start_cnt == c0; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL reset_leds: got %h want 00", leds); end
        n_cmp++; if (u_if.query_x !== 8'h00 || u_if.query_y !== 8'h00) begin n_bad++;
            $display("FAIL reset_query: got %h/%h want 00/00", u_if.query_x, u_if.query_y); end
        n_cmp++; if (u_if.k_value !== 3'd3 || u_if.k_sel !== 1'b0) begin n_bad++;
            $display("FAIL reset_k: got k_sel=%b k_value=%0d want 0/3", u_if.k_sel, u_if.k_value); end
        n_cmp++; if (busy !== 1'b0 || start_cnt != 0) begin n_bad++;
            $display("FAIL reset_idle: got busy=%b starts=%0d want 0/0", busy, start_cnt); end
    endtask

    task automatic test_load;
        logic [7:0] v;
        int         m;
        switches = 8'h12;
        press(1, 2);
        repeat (3) @(negedge clk);
        n_cmp++; if (u_if.query_x !== 8'h00) begin n_bad++;
            $display("FAIL load_x_early: got %h want 00 (pulse before 4 cycles)", u_if.query_x); end
        @(negedge clk);
        n_cmp++; if (u_if.query_x !== 8'h12) begin n_bad++;
            $display("FAIL load_x_timing: got %h want 12", u_if.query_x); end
        exp_qx = 8'h12;
        repeat (4) @(negedge clk);
        switches = 8'h0F;
        press(2, 2);
        repeat (8) @(negedge clk);
        exp_qy = 8'h0F;
        n_cmp++; if (u_if.query_y !== exp_qy) begin n_bad++;
            $display("FAIL load_y: got %h want %h", u_if.query_y, exp_qy); end
        switches = 8'hAA;
        press(1, 1);
        repeat (10) @(negedge clk);
        n_cmp++; if (u_if.query_x !== exp_qx) begin n_bad++;
            $display("FAIL glitch_x: got %h want %h", u_if.query_x, exp_qx); end
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            m = int'($urandom_range(1, 3));
            switches = v;
            press(m, 2 + int'($urandom_range(0, 2)));
            repeat (10) @(negedge clk);
            if (m[0]) exp_qx = v;
            if (m[1]) exp_qy = v;
            n_cmp++; if (u_if.query_x !== exp_qx || u_if.query_y !== exp_qy) begin n_bad++;
                $display("FAIL load_rand%0d: got %h/%h want %h/%h", i, u_if.query_x, u_if.query_y, exp_qx, exp_qy); end
        end
    endtask

    task automatic test_start_stale;
        int c0;
        int lat;
        logic cls;
        int stale;
        int dat;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                stale = 3; dat = 17; cls = 1'b1;
            end else begin
                stale = int'($urandom_range(0, 4));
                dat   = stale + 2 + int'($urandom_range(0, 35));
                cls   = 1'($urandom);
            end
            eng_stale = stale; eng_done_at = dat; eng_cls_v = cls;
            lat = ref_latency(stale, dat);
            c0 = start_cnt;
            press(4, 2);
            wait_start(c0);
            n_cmp++; if (start_cnt != c0 + 1 || busy !== 1'b1) begin n_bad++;
                $display("FAIL run%0d_start: got starts=%0d busy=%b want %0d/1", i, start_cnt - c0, busy, 1); end
            wait_idle(dat + 20);
            repeat (3) @(negedge clk);
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL run%0d_busy: got %b want 0", i, busy); end
            n_cmp++; if (leds[0] !== cls || leds[1] !== exp_k) begin n_bad++;
                $display("FAIL run%0d_cls: got cls=%b k=%b want %b/%b", i, leds[0], leds[1], cls, exp_k); end
            n_cmp++; if (leds[7:2] !== 6'(lat)) begin n_bad++;
                $display("FAIL run%0d_lat: got %0d want %0d", i, leds[7:2], lat); end
            repeat (10) @(negedge clk);
            n_cmp++; if (start_cnt != c0 + 1) begin n_bad++;
                $display("FAIL run%0d_one_pulse: got %0d pulses want 1", i, start_cnt - c0); end
        end
    endtask

    task automatic test_toggle;
        int c0;
        press(8, 2);
        repeat (8) @(negedge clk);
        exp_k = ~exp_k;
        n_cmp++; if (u_if.k_sel !== exp_k || u_if.k_value !== (exp_k ? 3'd5 : 3'd3) || leds[1] !== exp_k) begin n_bad++;
            $display("FAIL toggle: got k_sel=%b k_value=%0d led=%b want %b", u_if.k_sel, u_if.k_value, leds[1], exp_k); end
        eng_stale = 0; eng_done_at = 40; eng_cls_v = 1'b0;
        c0 = start_cnt;
        press(4, 2);
        wait_start(c0);
        repeat (2) @(negedge clk);
        switches = ~exp_qx;
        press(9, 2);
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || u_if.k_sel !== exp_k || u_if.query_x !== exp_qx) begin n_bad++;
            $display("FAIL drop_in_wait: got busy=%b k=%b qx=%h want 1/%b/%h", busy, u_if.k_sel, u_if.query_x, exp_k, exp_qx); end
        wait_idle(80);
        repeat (8) @(negedge clk);
        n_cmp++; if (u_if.k_sel !== exp_k || u_if.query_x !== exp_qx || leds[7:2] !== 6'(ref_latency(0, 40))) begin n_bad++;
            $display("FAIL no_queue: got k=%b qx=%h lat=%0d want %b/%h/%0d", u_if.k_sel, u_if.query_x, leds[7:2], exp_k, exp_qx, ref_latency(0, 40)); end
    endtask

    task automatic test_saturate;
        int c0;
        logic cls;
        cls = 1'($urandom);
        eng_stale = 0; eng_done_at = 80; eng_cls_v = cls;
        c0 = start_cnt;
        press(4, 2);
        wait_start(c0);
        wait_idle(200);
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || leds[7:2] !== 6'(ref_latency(0, 80)) || leds[0] !== cls) begin n_bad++;
            $display("FAIL saturate: got busy=%b lat=%0d cls=%b want 0/%0d/%b", busy, leds[7:2], leds[0], ref_latency(0, 80), cls); end
    endtask

    task automatic test_reset_mid;
        int c0;
        eng_stale = 0; eng_done_at = 100000; eng_cls_v = 1'b1;
        c0 = start_cnt;
        press(4, 2);
        wait_start(c0);
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hang_busy: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_qx = 8'h00; exp_qy = 8'h00; exp_k = 1'b0;
        n_cmp++; if (busy !== 1'b0 || leds !== 8'h00 || u_if.k_sel !== 1'b0 || u_if.eng_start !== 1'b0) begin n_bad++;
            $display("FAIL reset_mid: got busy=%b leds=%h k=%b start=%b want 0/00/0/0", busy, leds, u_if.k_sel, u_if.eng_start); end
        n_cmp++; if (u_if.query_x !== exp_qx || u_if.query_y !== exp_qy) begin n_bad++;
            $display("FAIL reset_mid_query: got %h/%h want 00/00", u_if.query_x, u_if.query_y); end
        c0 = start_cnt;
        repeat (10) @(negedge clk);
        n_cmp++; if (start_cnt != c0) begin n_bad++;
            $display("FAIL reset_mid_nostart: got %0d pulses want 0", start_cnt - c0); end
    endtask

    task automatic test_back_to_back;
        int c0;
        int dat;
        logic [7:0] v;
        for (int i = 0; i < 3; i++) begin
            v   = 8'($urandom);
            dat = 2 + int'($urandom_range(0, 30));
            eng_stale = 0; eng_done_at = dat; eng_cls_v = 1'($urandom);
            switches = v;
            c0 = start_cnt;
            press(15, 2);
            exp_qx = v; exp_qy = v; exp_k = ~exp_k;
            wait_start(c0);
            n_cmp++; if (start_cnt != c0 + 1 || seen_qx !== exp_qx || seen_qy !== exp_qy || seen_k !== exp_k) begin n_bad++;
                $display("FAIL b2b%0d_launch: got starts=%0d q=%h/%h k=%b want 1 %h/%h %b", i, start_cnt - c0, seen_qx, seen_qy, seen_k, exp_qx, exp_qy, exp_k); end
            wait_idle(dat + 20);
            repeat (8) @(negedge clk);
            n_cmp++; if (busy !== 1'b0 || leds !== {6'(ref_latency(0, dat)), exp_k, eng_cls_v}) begin n_bad++;
                $display("FAIL b2b%0d_result: got busy=%b leds=%h want 0/%h", i, busy, leds, {6'(ref_latency(0, dat)), exp_k, eng_cls_v}); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_load;
        test_start_stale;
        test_toggle;
        test_saturate;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/knn_front_ctrl.md
Name: knn_front_ctrl

Overview:
- Operator front-end that sits directly upstream of the k-NN classification engine on the board.
- Synchronises and debounces the four push-buttons.
- Latches query coordinates from the switches and owns the K-mode (K=3/K=5) select.
- Issues a single-cycle start to the engine, times the engine's run, and latches class, K-mode and latency onto the 8 LEDs.

Parameters:
DB_CYCLES, 2, consecutive stable synchronised samples required to accept a button level change (>=1)
LAT_W, 6, latency counter width; saturates at 2^LAT_W-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
switches  in  8  query coordinate, signed Q4.4 (8'h12 = +1.125, 8'hF0 = -1.0)
btn_load_x  in  1  raw button: latch switches into query_x
btn_load_y  in  1  raw button: latch switches into query_y
btn_start  in  1  raw button: launch classification
btn_toggle_k  in  1  raw button: toggle K mode
eng_done  in  1  engine done level (may remain high from previous run)
eng_class  in  1  engine predicted class, valid while eng_done=1
query_x  out  8  latched x coordinate to engine
query_y  out  8  latched y coordinate to engine
k_sel  out  1  0 = K=3, 1 = K=5
k_value  out  3  3'd3 when k_sel=0, 3'd5 when k_sel=1 (combinational from k_sel)
eng_start  out  1  one-cycle start pulse to engine
busy  out  1  high in START and WAIT_DONE
leds  out  8  [0]=latched class, [1]=k_sel, [7:2]=latched latency

Behaviour:
- Reset (sync, high): query_x=query_y=0, k_sel=0, eng_start=0, busy=0, leds=0, FSM=IDLE, all sync/debounce flops and counters 0.
- Per button: 2-flop synchroniser -> debouncer.
  - Counter increments while the sync output differs from the stable level; it clears when they match.
  - When count reaches DB_CYCLES, stable <= sync output and the counter clears.
  - A rising edge of stable gives a registered press pulse, high exactly 1 cycle.
  - With DB_CYCLES=2, a press held 2 cycles gives its pulse 2+DB_CYCLES=4 cycles after the first clock edge sampling it high.
  - A 1-cycle glitch produces no pulse.
  - A button held through reset yields a press after debounce.
- FSM states IDLE, START, WAIT_DONE, RESULT.
  - IDLE/RESULT:
    - load_x press: query_x <= switches, sampled in the pulse cycle. load_y the same into query_y.
    - toggle press: k_sel <= ~k_sel.
    - These actions are independent; same-cycle presses all apply.
    - start press -> START, also taken in a cycle where loads/toggle apply.
  - START (1 cycle): eng_start=1, latency counter <= 0, done_armed <= 0 -> WAIT_DONE. The engine therefore always sees updated query/K.
  - WAIT_DONE:
    - Counter increments each cycle, saturating at 63.
    - done_armed sets on the first cycle eng_done=0; a stale high eng_done is ignored until armed.
    - When done_armed=1 and eng_done=1: leds[0] <= eng_class, leds[7:2] <= number of WAIT_DONE cycles including this one (saturated 63), -> RESULT.
  - RESULT: holds LEDs; behaves as IDLE for button handling.
- leds[1] tracks k_sel live in every state.
- In START/WAIT_DONE all presses (load_x, load_y, toggle, start) are dropped, not queued.
- No timeout: if the engine never completes, the block stays in WAIT_DONE until reset.
- Reset in any state returns to IDLE within the same edge; an in-flight run is abandoned and eng_start stays 0.

Test Plan:
1. Reset then idle 10 cycles -> leds=8'h00, query_x=query_y=0, k_value=3, eng_start never high.
2. switches=8'h12, btn_load_x high 2 cycles; switches=8'h0F, btn_load_y high 2 cycles -> query_x=8'h12, query_y=8'h0F. A 1-cycle btn_load_x glitch with switches=8'hAA leaves query_x=8'h12.
3. Start press; engine model holds eng_done=1 for 3 cycles after eng_start, then low, then high 17 cycles after eng_start with eng_class=1 -> exactly one eng_start pulse, stale done ignored, leds[0]=1, leds[7:2]=17, busy falls.
4. Toggle press in RESULT -> k_sel=1, k_value=5, leds[1]=1. A second toggle and a load_x press during WAIT_DONE are ignored (k_sel and query_x unchanged).
5. Engine done delayed 80 cycles -> leds[7:2]=63 (saturated).
6. Reset asserted mid-WAIT_DONE -> next cycle FSM=IDLE, leds=0, k_sel=0, no eng_start. A later start runs normally.
